// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: BusCtrl-side write port and FIFO status of the UART transmitter.
interface uart_tx_if;
    logic [7:0] iData;
    logic       iWe;
    logic       oFull;
    logic       oEmpty;

    modport master (output iData, iWe, input oFull, oEmpty);
    modport slave  (input iData, iWe, output oFull, oEmpty);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head and a registered occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             wr, rd;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem_q[rp_q];

    always_ff @(posedge clk)
        if (wr) mem_q[wp_q] <= wdata;

    // pointers wrap naturally at AW bits; a push while full is ignored even if popping
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: bus-mapped 8N1 transmitter; bytes queue in a FIFO and are shifted out LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     oBusy,
    output logic     oTx
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int IW  = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, head;
    logic                 tx_q, tx_d, busy_q, busy_d;
    logic                 pop, empty, tick;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.iWe),
        .pop   (pop),
        .wdata (bus.iData),
        .rdata (head),
        .full  (bus.oFull),
        .empty (empty)
    );

    assign bus.oEmpty = empty;
    assign tick       = cnt_q == CW'(DIV - 1);
    assign oTx        = tx_q;
    assign oBusy      = busy_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE:  if (!empty) begin
                       state_d = START;
                       shift_d = head;
                   end
            START: if (tick) begin
                       state_d = DATA;
                       idx_d   = '0;
                   end
            DATA:  if (tick) begin
                       shift_d = shift_q >> 1;
                       idx_d   = idx_q + 1'b1;
                       if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
                   end
            STOP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // line and busy are registered one cycle behind the state so they stay aligned
    always_comb begin
        pop    = state_q == IDLE && !empty;
        busy_d = state_q != IDLE;
        tx_d   = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx timing against a vector table and decodes oTx into a byte scoreboard.
module tb_uart_tx;
    localparam int CLK_HZ = 400;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 16;
    localparam int DIV    = 4;
    localparam int FRAME  = 10 * DIV;

    typedef struct {
        int   k;
        logic tx;
        logic busy;
        logic empty;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, tx;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         nrx = 0;
    logic [7:0] sb[$];
    int         starts[$];
    vec_t       v[16];

    uart_tx_if bus();

    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .oBusy (busy),
        .oTx   (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit acc);
        bus.iData = b;
        bus.iWe   = 1'b1;
        if (acc) sb.push_back(b);
        @(negedge clk);
        bus.iWe = 1'b0;
    endtask

    task automatic drain(input int n0, input int nexp);
        int t = 0;
        while (sb.size() != 0 && t < 30 * FRAME) begin
            @(negedge clk);
            t++;
        end
        repeat (2 * FRAME) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        chk("frame_count", nrx - n0, nexp);
    endtask

    // Line monitor: samples each bit mid-cell; frames overlapping a reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic       ab;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                repeat (2) @(negedge clk);
                ab |= rst;
                if (!ab) chk1("start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    ab |= rst;
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                ab |= rst;
                if (!ab) begin
                    chk1("stop_bit", tx, 1'b1);
                    chk("rx_expected", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) chk("rx_byte", int'(b), int'(sb.pop_front()));
                    nrx++;
                end
            end
        end
    end

    initial begin
        int n0, cur, lows, sent, t;
        bus.iData = '0;
        bus.iWe   = 1'b0;
        // {cycle offset after the push edge, oTx, oBusy, oEmpty} for byte 0xA5
        v = '{'{0, 1'b1, 1'b0, 1'b0}, '{1, 1'b1, 1'b0, 1'b1}, '{2, 1'b0, 1'b1, 1'b1},
              '{5, 1'b0, 1'b1, 1'b1}, '{6, 1'b1, 1'b1, 1'b1}, '{9, 1'b1, 1'b1, 1'b1},
              '{10, 1'b0, 1'b1, 1'b1}, '{14, 1'b1, 1'b1, 1'b1}, '{18, 1'b0, 1'b1, 1'b1},
              '{22, 1'b0, 1'b1, 1'b1}, '{26, 1'b1, 1'b1, 1'b1}, '{30, 1'b0, 1'b1, 1'b1},
              '{34, 1'b1, 1'b1, 1'b1}, '{38, 1'b1, 1'b1, 1'b1}, '{41, 1'b1, 1'b1, 1'b1},
              '{42, 1'b1, 1'b0, 1'b1}};

        repeat (3) @(negedge clk);
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_full", bus.oFull, 1'b0);
        chk1("rst_empty", bus.oEmpty, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single byte, exact cycle timing
        n0 = nrx;
        wr(8'hA5, 1'b1);
        cur = 0;
        foreach (v[i]) begin
            repeat (v[i].k - cur) @(negedge clk);
            cur = v[i].k;
            chk1($sformatf("t1_tx@%0d", v[i].k), tx, v[i].tx);
            chk1($sformatf("t1_busy@%0d", v[i].k), busy, v[i].busy);
            chk1($sformatf("t1_empty@%0d", v[i].k), bus.oEmpty, v[i].empty);
        end
        drain(n0, 1);

        // back-to-back frames separated by one idle cycle
        n0 = nrx;
        starts.delete();
        wr(8'h00, 1'b1);
        wr(8'hFF, 1'b1);
        wr(8'h3C, 1'b1);
        drain(n0, 3);
        chk("t2_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t2_gap0", starts[1] - starts[0], FRAME + 1);
            chk("t2_gap1", starts[2] - starts[1], FRAME + 1);
        end

        // overflow while busy, then a write colliding with the pop while full
        n0 = nrx;
        wr(8'h11, 1'b1);
        @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr(8'(8'h20 + i), i < DEPTH);
            chk1($sformatf("t3_full%0d", i), bus.oFull, i >= DEPTH - 1);
        end
        repeat (22) @(negedge clk);
        chk1("t4_full_before", bus.oFull, 1'b1);
        wr(8'hEE, 1'b0);
        chk1("t4_full_after", bus.oFull, 1'b0);
        chk1("t4_empty_after", bus.oEmpty, 1'b0);
        drain(n0, DEPTH + 1);

        // reset during the fifth data bit with three bytes queued
        n0 = nrx;
        wr(8'hC6, 1'b1);
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        repeat (20) @(negedge clk);
        chk1("t5_bit4", tx, 1'b0);
        chk1("t5_busy_pre", busy, 1'b1);
        chk1("t5_empty_pre", bus.oEmpty, 1'b0);
        rst = 1'b1;
        #1;
        chk1("t5_tx", tx, 1'b1);
        chk1("t5_empty", bus.oEmpty, 1'b1);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_full", bus.oFull, 1'b0);
        sb.delete();
        repeat (4) @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t5_quiet_lows", lows, 0);
        chk1("t5_empty_post", bus.oEmpty, 1'b1);
        chk1("t5_busy_post", busy, 1'b0);
        chk("t5_no_frames", nrx - n0, 0);
        n0 = nrx;
        wr(8'h5A, 1'b1);
        drain(n0, 1);

        // random writes, paced so every write is guaranteed to be accepted
        n0   = nrx;
        sent = 0;
        t    = 0;
        while (sent < 30 && t < 5000) begin
            if (sb.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                wr(8'($urandom), 1'b1);
                sent++;
            end else begin
                @(negedge clk);
            end
            t++;
        end
        chk("t6_sent", sent, 30);
        drain(n0, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
